// File: rtl/montgomery_mult_serial_if.sv
// Handshake and operand bus between the modular-exponentiation controller (master)
// and the bit-serial Montgomery multiplier (slave).
//   enable       master -> slave  level request, held until done is seen
//   m, x, y      master -> slave  modulus and operands, sampled at start
//   R            master -> slave  2^WORD_WIDTH, compatibility only
//   done         slave -> master  high while the result is presented
//   mult_result  slave -> master  x*y*R^-1 mod m
//   op_err       slave -> master  operand error flag
interface montgomery_mult_serial_if #(
    parameter int WORD_WIDTH = 32
);
    logic                  enable;
    logic                  done;
    logic [WORD_WIDTH-1:0] m;
    logic [WORD_WIDTH-1:0] x;
    logic [WORD_WIDTH-1:0] y;
    logic [WORD_WIDTH:0]   R;
    logic [WORD_WIDTH-1:0] mult_result;
    logic                  op_err;

    modport master (
        output enable, m, x, y, R,
        input  done, mult_result, op_err
    );

    modport slave (
        input  enable, m, x, y, R,
        output done, mult_result, op_err
    );
endinterface

// File: rtl/montgomery_mult_serial.sv
// Bit-serial radix-2 Montgomery multiplier: mult_result = x*y*R^-1 mod m, R = 2^WORD_WIDTH.
// One multiplier bit is consumed per clock; a result is ready WORD_WIDTH+2 cycles after start.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high; returns to idle and clears all outputs
//   bus    montgomery_mult_serial_if slave modport (enable/done handshake, m/x/y operands,
//          unused R, mult_result, op_err)
// Optional feature: define MONT_MULT_OPERAND_CHECK_EN to reject even m or x/y >= m; the
// operation then completes at once with mult_result=0 and op_err=1. Without it op_err is 0.
module montgomery_mult_serial #(
    parameter int WORD_WIDTH = 32
) (
    input logic                    clk,
    input logic                    reset,
    montgomery_mult_serial_if.slave bus
);
    localparam int CNT_W = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;
    localparam int ACC_W = WORD_WIDTH + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StIter, StCorrect, StDone} state_e;

    state_e                state_q;
    logic [WORD_WIDTH-1:0] m_q;
    logic [WORD_WIDTH-1:0] x_q;
    logic [WORD_WIDTH-1:0] y_q;
    logic [ACC_W-1:0]      acc_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  done_q;
    logic [WORD_WIDTH-1:0] result_q;

    logic [WORD_WIDTH+1:0] t_sum;
    logic [WORD_WIDTH+1:0] t_add;
    logic [WORD_WIDTH-1:0] acc_sub;
    logic [WORD_WIDTH-1:0] corrected;

    always_comb begin
        t_sum = {1'b0, acc_q} + (x_q[cnt_q] ? {2'b00, y_q} : '0);
        // Adding m when odd makes t divisible by 2 without changing its residue.
        t_add = t_sum[0] ? (t_sum + {2'b00, m_q}) : t_sum;
        // acc < 2m, so the low bits of acc-m are exact whenever acc >= m.
        acc_sub   = acc_q[WORD_WIDTH-1:0] - m_q;
        corrected = (acc_q >= {1'b0, m_q}) ? acc_sub : acc_q[WORD_WIDTH-1:0];
    end

`ifdef MONT_MULT_OPERAND_CHECK_EN
    logic op_err_q;
    logic ops_bad;

    always_comb begin
        ops_bad = !bus.m[0] || (bus.x >= bus.m) || (bus.y >= bus.m);
    end

    assign bus.op_err = op_err_q;
`else
    assign bus.op_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            m_q      <= '0;
            x_q      <= '0;
            y_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            result_q <= '0;
`ifdef MONT_MULT_OPERAND_CHECK_EN
            op_err_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                StIdle: begin
                    if (bus.enable) begin
                        m_q     <= bus.m;
                        x_q     <= bus.x;
                        y_q     <= bus.y;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= StIter;
`ifdef MONT_MULT_OPERAND_CHECK_EN
                        op_err_q <= 1'b0;
                        // Later assignments override the normal start path.
                        if (ops_bad) begin
                            result_q <= '0;
                            op_err_q <= 1'b1;
                            done_q   <= 1'b1;
                            state_q  <= StDone;
                        end
`endif
                    end
                end
                StIter: begin
                    if (!bus.enable) begin
                        state_q <= StIdle;
                    end else begin
                        acc_q <= ACC_W'(t_add >> 1);
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == CNT_LAST) begin
                            state_q <= StCorrect;
                        end
                    end
                end
                StCorrect: begin
                    if (!bus.enable) begin
                        state_q <= StIdle;
                    end else begin
                        result_q <= corrected;
                        done_q   <= 1'b1;
                        state_q  <= StDone;
                    end
                end
                StDone: begin
                    if (!bus.enable) begin
                        done_q  <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.done        = done_q;
    assign bus.mult_result = result_q;
endmodule
